// File: rtl/des_pkg.sv
// Shared constants for the DES key schedule: permutation tables, the
// per-round shift schedule, the FSM state type and a 28-bit rotate helper.
package des_pkg;

  // Number of round keys in one DES key schedule.
  localparam logic [4:0] NUM_ROUNDS = 5'd16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // PC-1: key bit number (1 = MSB, 1..64) feeding each of the 56 C/D bits.
  localparam int unsigned PC1_TABLE [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: {C,D} bit number (1..56) feeding each of the 48 round-key bits.
  localparam int unsigned PC2_TABLE [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Rotation amount applied to reach round key n (left for encryption).
  localparam logic [1:0] SHIFT_SCHED [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Rotate one 28-bit half by 0, 1 or 2 places; bit 1 is the MSB, so a
  // left rotation moves bit 1 round to bit 28.
  function automatic logic [1:28] rot28(input logic [1:28] v,
                                        input logic [1:0]  amt,
                                        input logic        toRight);
    logic [1:28] r;
    r = v;
    if (toRight) begin
      if (amt == 2'd2) begin
        r = {v[27:28], v[1:26]};
      end else if (amt == 2'd1) begin
        r = {v[28], v[1:27]};
      end
    end else begin
      if (amt == 2'd2) begin
        r = {v[3:28], v[1:2]};
      end else if (amt == 2'd1) begin
        r = {v[2:28], v[1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted Choice 2: selects the 48 round-key bits from the 56-bit {C,D}
// state. Purely combinational so it can be reused per stage in a pipeline.
module des_pc2
  import des_pkg::*;
(
  input  logic [1:56] cd_i,
  output logic [1:48] key_o
);

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign key_o[i+1] = cd_i[PC2_TABLE[i]];
  end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule. Holds the C/D halves and steps them one
// rotation per 'next' request, left for encryption (K1..K16) and right for
// decryption (K16..K1), so no precompute pass is needed in either direction.
module des_key_sched
  import des_pkg::*;
#(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [1:64] key,
  input  logic        decrypt,
  input  logic        next,
  output logic [1:48] roundKey,
  output logic [4:0]  round,
  output logic        key_valid,
  output logic        last,
  output logic        parity_err
);

  state_e      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [4:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic        perr_q, perr_d;

  logic [1:56] pc1Key;
  logic [1:28] loadC;
  logic [1:28] loadD;
  logic        keyParityBad;
  logic [4:0]  stepIdx;
  logic [1:0]  shiftAmt;

  // PC-1 is only needed when a key is captured, so it lives here rather
  // than in its own module.
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1Key[i+1] = key[PC1_TABLE[i]];
  end

  // Encryption starts from C1/D1 (one left rotation); decryption starts from
  // C0/D0, which equals C16/D16 because the full schedule rotates by 28.
  always_comb begin
    loadC = pc1Key[1:28];
    loadD = pc1Key[29:56];
    if (!decrypt) begin
      loadC = rot28(pc1Key[1:28],  SHIFT_SCHED[1], 1'b0);
      loadD = rot28(pc1Key[29:56], SHIFT_SCHED[1], 1'b0);
    end
  end

  // A key byte is bad when it holds an even number of ones.
  always_comb begin
    keyParityBad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[b*8+1 +: 8])) begin
        keyParityBad = 1'b1;
      end
    end
  end

  // Going forward to key n+1 uses s[n+1]; walking backwards from key
  // 17-n undoes the rotation s[17-n] that produced it.
  always_comb begin
    stepIdx  = dec_q ? (5'd17 - round_q) : (round_q + 5'd1);
    shiftAmt = 2'd0;
    if ((stepIdx >= 5'd1) && (stepIdx <= NUM_ROUNDS)) begin
      shiftAmt = SHIFT_SCHED[stepIdx];
    end
  end

  // Next-state logic: a load always wins and restarts at round 1; in RUN a
  // 'next' advances one round or retires the schedule after round 16.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    perr_d  = perr_q;
    if (load) begin
      state_d = ST_RUN;
      c_d     = loadC;
      d_d     = loadD;
      round_d = 5'd1;
      dec_d   = decrypt;
      perr_d  = (PARITY_CHECK != 0) && keyParityBad;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (next) begin
            if (round_q == NUM_ROUNDS) begin
              state_d = ST_IDLE;
              round_d = 5'd0;
            end else begin
              round_d = round_q + 5'd1;
              c_d     = rot28(c_q, shiftAmt, dec_q);
              d_d     = rot28(d_q, shiftAmt, dec_q);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= 5'd0;
      dec_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      perr_q  <= perr_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i  ({c_q, d_q}),
    .key_o (roundKey)
  );

  assign round      = round_q;
  assign key_valid  = (state_q == ST_RUN);
  assign last       = (state_q == ST_RUN) && (round_q == NUM_ROUNDS);
  assign parity_err = (PARITY_CHECK != 0) ? perr_q : 1'b0;

endmodule

// File: tb/tb_des_key_sched.sv
// Testbench for des_key_sched. Two instances (parity checking off and on)
// share stimulus; a textbook key-schedule model predicts every output.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        next = 1'b0;

  logic [47:0] rk0, rk1;
  logic [4:0]  round0, round1;
  logic        valid0, valid1, last0, last1, perr0, perr1;

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] ALT_KEY  = 64'h0E329232EA6D0D73;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  des_key_sched #(.PARITY_CHECK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .key(key), .decrypt(decrypt),
    .next(next), .roundKey(rk0), .round(round0), .key_valid(valid0),
    .last(last0), .parity_err(perr0));

  des_key_sched #(.PARITY_CHECK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .key(key), .decrypt(decrypt),
    .next(next), .roundKey(rk1), .round(round1), .key_valid(valid1),
    .last(last1), .parity_err(perr1));

  // Round key n straight from the DES definition: PC-1, rotate each half by
  // the cumulative shift total, then PC-2. Bit p (1 = MSB) of a W-bit value
  // sits at index W-p.
  function automatic logic [47:0] roundKeyOf(input logic [63:0] k, input int n);
    logic [55:0] cd0, cdn;
    logic [47:0] r;
    int total;
    for (int p = 1; p <= 56; p++) cd0[56-p] = k[64-PC1[p-1]];
    total = 0;
    for (int i = 1; i <= n; i++) total += SHIFTS[i-1];
    for (int p = 1; p <= 28; p++) begin
      cdn[56-p]      = cd0[56-(((p-1+total) % 28) + 1)];
      cdn[56-(28+p)] = cd0[56-(28 + ((p-1+total) % 28) + 1)];
    end
    for (int p = 1; p <= 48; p++) r[48-p] = cdn[56-PC2[p-1]];
    return r;
  endfunction

  function automatic logic parityBad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (($countones(k[63-8*b -: 8]) % 2) == 0) bad = 1'b1;
    end
    return bad;
  endfunction

  // Reference model state: what the schedule should present right now.
  logic        mValid = 1'b0;
  int          mRound = 0;
  logic        mDec = 1'b0;
  logic        mPerr = 1'b0;
  logic [63:0] mKey = '0;
  logic [47:0] mCur = '0;

  // Model update on each clock edge from the same inputs the DUTs sample.
  always @(posedge clk) begin
    if (!rst_n) begin
      mValid = 1'b0;
      mRound = 0;
      mPerr  = 1'b0;
      mCur   = '0;
    end else if (load) begin
      mKey   = key;
      mDec   = decrypt;
      mValid = 1'b1;
      mRound = 1;
      mPerr  = parityBad(key);
      mCur   = roundKeyOf(key, decrypt ? 16 : 1);
    end else if (mValid && next) begin
      if (mRound == 16) begin
        mValid = 1'b0;
        mRound = 0;
      end else begin
        mRound = mRound + 1;
        mCur   = roundKeyOf(mKey, mDec ? 17 - mRound : mRound);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, both instances are compared with the model midway between edges.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmp0_roundKey", {16'h0, rk0}, {16'h0, mCur});
      checkOutput("cmp0_round", {59'h0, round0}, 64'(mRound));
      checkOutput("cmp0_valid", {63'h0, valid0}, {63'h0, mValid});
      checkOutput("cmp0_last", {63'h0, last0}, {63'h0, (mValid && mRound == 16)});
      checkOutput("cmp0_parity", {63'h0, perr0}, 64'h0);
      checkOutput("cmp1_roundKey", {16'h0, rk1}, {16'h0, mCur});
      checkOutput("cmp1_round", {59'h0, round1}, 64'(mRound));
      checkOutput("cmp1_valid", {63'h0, valid1}, {63'h0, mValid});
      checkOutput("cmp1_parity", {63'h0, perr1}, {63'h0, mPerr});
    end
  end

  // One clock of stimulus; the pulse inputs drop again after the edge.
  task automatic applyStimulus(input bit ld, input logic [63:0] k,
                               input bit dec, input bit nx);
    load    = ld;
    key     = k;
    decrypt = dec;
    next    = nx;
    @(posedge clk);
    #1;
    load = 1'b0;
    next = 1'b0;
  endtask

  initial begin
    // Model pinned against the published DES example schedule.
    checkOutput("model_K1",  {16'h0, roundKeyOf(GOLD_KEY, 1)},  {16'h0, 48'h1B02EFFC7072});
    checkOutput("model_K2",  {16'h0, roundKeyOf(GOLD_KEY, 2)},  {16'h0, 48'h79AED9DBC9E5});
    checkOutput("model_K16", {16'h0, roundKeyOf(GOLD_KEY, 16)}, {16'h0, 48'hCB3D8B0E17F5});

    // Reset.
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    checkOutput("reset_valid", {63'h0, valid0}, 64'h0);
    checkOutput("reset_round", {59'h0, round0}, 64'h0);
    checkOutput("reset_roundKey", {16'h0, rk0}, 64'h0);
    checkOutput("reset_parity", {63'h0, perr1}, 64'h0);
    rst_n = 1'b1;

    // Encrypt walk-through.
    applyStimulus(1'b1, GOLD_KEY, 1'b0, 1'b0);
    checkOutput("enc_r1_round", {59'h0, round0}, 64'd1);
    checkOutput("enc_r1_key", {16'h0, rk0}, {16'h0, 48'h1B02EFFC7072});
    applyStimulus(1'b0, GOLD_KEY, 1'b0, 1'b1);
    checkOutput("enc_r2_round", {59'h0, round0}, 64'd2);
    checkOutput("enc_r2_key", {16'h0, rk0}, {16'h0, 48'h79AED9DBC9E5});
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, GOLD_KEY, 1'b0, 1'b1);
    checkOutput("enc_r16_round", {59'h0, round0}, 64'd16);
    checkOutput("enc_r16_last", {63'h0, last0}, 64'd1);
    checkOutput("enc_r16_key", {16'h0, rk0}, {16'h0, 48'hCB3D8B0E17F5});
    applyStimulus(1'b0, GOLD_KEY, 1'b0, 1'b1);
    checkOutput("enc_done_valid", {63'h0, valid0}, 64'h0);
    checkOutput("enc_done_round", {59'h0, round0}, 64'h0);

    // Decrypt walk-through.
    applyStimulus(1'b1, GOLD_KEY, 1'b1, 1'b0);
    checkOutput("dec_r1_key", {16'h0, rk0}, {16'h0, 48'hCB3D8B0E17F5});
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, GOLD_KEY, 1'b0, 1'b1);
    checkOutput("dec_r16_round", {59'h0, round0}, 64'd16);
    checkOutput("dec_r16_key", {16'h0, rk0}, {16'h0, 48'h1B02EFFC7072});
    applyStimulus(1'b0, GOLD_KEY, 1'b0, 1'b1);

    // Stall at round 5 for ten cycles, then resume.
    applyStimulus(1'b1, GOLD_KEY, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, GOLD_KEY, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, GOLD_KEY, 1'b1, 1'b0);
    checkOutput("stall_round", {59'h0, round0}, 64'd5);
    checkOutput("stall_key", {16'h0, rk0}, {16'h0, roundKeyOf(GOLD_KEY, 5)});
    applyStimulus(1'b0, GOLD_KEY, 1'b1, 1'b1);
    checkOutput("resume_key", {16'h0, rk0}, {16'h0, roundKeyOf(GOLD_KEY, 6)});

    // Reload mid-sequence at round 9 with a new key; load wins over next.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, GOLD_KEY, 1'b0, 1'b1);
    applyStimulus(1'b1, ALT_KEY, 1'b0, 1'b1);
    checkOutput("reload_round", {59'h0, round0}, 64'd1);
    checkOutput("reload_key", {16'h0, rk0}, {16'h0, roundKeyOf(ALT_KEY, 1)});

    // Parity reporting.
    applyStimulus(1'b1, 64'h0101010101010101, 1'b0, 1'b0);
    checkOutput("parity_good", {63'h0, perr1}, 64'h0);
    applyStimulus(1'b1, 64'h0001010101010101, 1'b0, 1'b0);
    checkOutput("parity_bad", {63'h0, perr1}, 64'h1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, GOLD_KEY, 1'b0, 1'b1);
    checkOutput("parity_held", {63'h0, perr1}, 64'h1);
    checkOutput("parity_off", {63'h0, perr0}, 64'h0);

    // Reset during RUN at round 7, then next while idle.
    checkOutput("pre_reset_round", {59'h0, round0}, 64'd7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("run_reset_valid", {63'h0, valid0}, 64'h0);
    checkOutput("run_reset_round", {59'h0, round0}, 64'h0);
    checkOutput("run_reset_key", {16'h0, rk0}, 64'h0);
    checkOutput("run_reset_parity", {63'h0, perr1}, 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, GOLD_KEY, 1'b0, 1'b1);
    checkOutput("idle_next_valid", {63'h0, valid0}, 64'h0);

    // Randomized traffic checked every cycle by the compare process.
    applyStimulus(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus(($urandom_range(0, 24) == 0), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
